// File: rtl/dfi_data_sched_if.sv
// Command channel between the command generator and the DFI data-phase
// scheduler.
//
// Handshake: a request transfers on any rising clk edge where cmd_valid and
// cmd_ready are both high. The scheduler may lower cmd_ready at any time,
// for example while a configuration change drains. cmd_wr, cmd_rank and
// cmd_phase are sampled only on a transfer. cmd_err is a one-cycle pulse in
// the cycle after a transfer that was dropped.
//
// Signals:
//   cmd_valid  master->slave  burst request present
//   cmd_ready  slave->master  scheduler accepts requests this cycle
//   cmd_wr     master->slave  1 = write, 0 = read
//   cmd_rank   master->slave  target rank (binary)
//   cmd_phase  master->slave  DFI phase the command occupies
//   cmd_err    slave->master  previous transfer was rejected
interface dfi_data_sched_if #(
    parameter int pDFI_CS_WIDTH = 2
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_wr;
    logic [pDFI_CS_WIDTH-1:0] cmd_rank;
    logic [1:0]               cmd_phase;
    logic                     cmd_err;

    modport master (
        output cmd_valid, cmd_wr, cmd_rank, cmd_phase,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_rank, cmd_phase,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/dfi_data_sched.sv
// DFI data-phase scheduler.
//
// Takes read/write burst requests and drives the per-phase DFI write and read
// data enables and chip selects at the programmed latencies, for 1:1, 1:2
// and 1:4 frequency ratios. Every future phase is held in two shift-register
// timelines, one for writes and one for reads. Each cycle the first N slots
// go to the output phases and the timeline shifts down by N. A configuration
// change waits for both timelines to empty before the new values take effect.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd                      request channel (slave side of dfi_data_sched_if)
//   cfg_update               pulse: capture cfg_* and start a drain/load
//   cfg_freq_ratio           0 = 1:1, 1 = 1:2, 2/3 = 1:4
//   cfg_tphy_wrlat           write latency in phases
//   cfg_trddata_en           read latency in phases
//   cfg_burst                burst length in phases
//   dfi_wrdata_en/cs_P0..P3  write enable (replicated) and one-hot rank per phase
//   dfi_rddata_en/cs_P0..P3  read enable (replicated) and one-hot rank per phase
//   sched_idle               both timelines empty and FSM in RUN
//   fsm_state                debug view of the FSM (0 RUN, 1 DRAIN, 2 LOAD)
module dfi_data_sched #(
    parameter int pDFI_CS_WIDTH        = 2,
    parameter int pDFI_WRDATA_EN_WIDTH = 3,
    parameter int pDFI_RDDATA_EN_WIDTH = 3,
    parameter int pMAX_LAT             = 40,
    parameter int pMAX_BURST           = 16,
    parameter int pTL_LEN              = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    dfi_data_sched_if.slave                 cmd,
    input  logic                            cfg_update,
    input  logic [1:0]                      cfg_freq_ratio,
    input  logic [5:0]                      cfg_tphy_wrlat,
    input  logic [5:0]                      cfg_trddata_en,
    input  logic [4:0]                      cfg_burst,
    output logic [pDFI_WRDATA_EN_WIDTH-1:0] dfi_wrdata_en_P0,
    output logic [pDFI_WRDATA_EN_WIDTH-1:0] dfi_wrdata_en_P1,
    output logic [pDFI_WRDATA_EN_WIDTH-1:0] dfi_wrdata_en_P2,
    output logic [pDFI_WRDATA_EN_WIDTH-1:0] dfi_wrdata_en_P3,
    output logic [pDFI_CS_WIDTH-1:0]        dfi_wrdata_cs_P0,
    output logic [pDFI_CS_WIDTH-1:0]        dfi_wrdata_cs_P1,
    output logic [pDFI_CS_WIDTH-1:0]        dfi_wrdata_cs_P2,
    output logic [pDFI_CS_WIDTH-1:0]        dfi_wrdata_cs_P3,
    output logic [pDFI_RDDATA_EN_WIDTH-1:0] dfi_rddata_en_P0,
    output logic [pDFI_RDDATA_EN_WIDTH-1:0] dfi_rddata_en_P1,
    output logic [pDFI_RDDATA_EN_WIDTH-1:0] dfi_rddata_en_P2,
    output logic [pDFI_RDDATA_EN_WIDTH-1:0] dfi_rddata_en_P3,
    output logic [pDFI_CS_WIDTH-1:0]        dfi_rddata_cs_P0,
    output logic [pDFI_CS_WIDTH-1:0]        dfi_rddata_cs_P1,
    output logic [pDFI_CS_WIDTH-1:0]        dfi_rddata_cs_P2,
    output logic [pDFI_CS_WIDTH-1:0]        dfi_rddata_cs_P3,
    output logic                            sched_idle,
    output logic [1:0]                      fsm_state
);

    localparam logic [6:0] MAX_LAT_V   = 7'(pMAX_LAT);
    localparam logic [5:0] MAX_BURST_V = 6'(pMAX_BURST);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ready;
    logic   load_en;
    logic   tl_empty;

    // Active configuration. n_act holds the phases per cycle (1, 2 or 4).
    logic [2:0] n_act;
    logic [5:0] wrlat_act, rdlat_act;
    logic [4:0] burst_act;

    // Copy captured at the most recent cfg_update pulse.
    logic [1:0] cap_ratio;
    logic [5:0] cap_wrlat, cap_rdlat;
    logic [4:0] cap_burst;

    // Timelines: slot 0 is the first phase of the next output cycle.
    logic [pTL_LEN-1:0]       wr_tl_en, rd_tl_en;
    logic [pDFI_CS_WIDTH-1:0] wr_tl_rank [pTL_LEN];
    logic [pDFI_CS_WIDTH-1:0] rd_tl_rank [pTL_LEN];

    // Timelines with this cycle's request merged in, and the shifted result.
    logic [pTL_LEN-1:0]       wr_mrg_en, rd_mrg_en;
    logic [pDFI_CS_WIDTH-1:0] wr_mrg_rank [pTL_LEN];
    logic [pDFI_CS_WIDTH-1:0] rd_mrg_rank [pTL_LEN];
    logic [pTL_LEN-1:0]       wr_nxt_en, rd_nxt_en;
    logic [pDFI_CS_WIDTH-1:0] wr_nxt_rank [pTL_LEN];
    logic [pDFI_CS_WIDTH-1:0] rd_nxt_rank [pTL_LEN];

    // Request decode.
    logic [5:0]         req_lat;
    logic [7:0]         req_start, req_end;
    logic [pTL_LEN-1:0] req_mask;
    logic               req_collide, req_bad, req_fire, req_ins;
    logic               err_q;

    // Output phase registers.
    logic [3:0]               wr_bit_d, rd_bit_d, wr_bit_q, rd_bit_q;
    logic [pDFI_CS_WIDTH-1:0] wr_cs_d [4];
    logic [pDFI_CS_WIDTH-1:0] rd_cs_d [4];
    logic [pDFI_CS_WIDTH-1:0] wr_cs_q [4];
    logic [pDFI_CS_WIDTH-1:0] rd_cs_q [4];

    function automatic logic [2:0] ratio_to_n(input logic [1:0] r);
        case (r)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Rank values with no matching cs bit give an all-zero select.
    function automatic logic [pDFI_CS_WIDTH-1:0] onehot(input logic [pDFI_CS_WIDTH-1:0] r);
        logic [pDFI_CS_WIDTH-1:0] v;
        v = '0;
        for (int b = 0; b < pDFI_CS_WIDTH; b++) begin
            if (r == pDFI_CS_WIDTH'(b)) v[b] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (cfg_update) state_nxt = ST_DRAIN;
            ST_DRAIN: if (tl_empty)   state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready      = (state == ST_RUN);
        load_en    = (state == ST_LOAD);
        sched_idle = (state == ST_RUN) && tl_empty;
        fsm_state  = state;
    end

    assign tl_empty      = ~|wr_tl_en & ~|rd_tl_en;
    assign cmd.cmd_ready = ready;
    assign cmd.cmd_err   = err_q;

    // ---------------- configuration ----------------
    // In LOAD, an update in that very cycle wins over the captured copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_ratio <= 2'd2;
            cap_wrlat <= 6'd0;
            cap_rdlat <= 6'd0;
            cap_burst <= 5'd1;
            n_act     <= 3'd4;
            wrlat_act <= 6'd0;
            rdlat_act <= 6'd0;
            burst_act <= 5'd1;
        end else begin
            if (cfg_update) begin
                cap_ratio <= cfg_freq_ratio;
                cap_wrlat <= cfg_tphy_wrlat;
                cap_rdlat <= cfg_trddata_en;
                cap_burst <= cfg_burst;
            end
            if (load_en) begin
                n_act     <= ratio_to_n(cfg_update ? cfg_freq_ratio : cap_ratio);
                wrlat_act <= cfg_update ? cfg_tphy_wrlat : cap_wrlat;
                rdlat_act <= cfg_update ? cfg_trddata_en : cap_rdlat;
                burst_act <= cfg_update ? cfg_burst      : cap_burst;
            end
        end
    end

    // ---------------- request decode ----------------
    // The target slots are phase+lat .. phase+lat+burst-1, counted from
    // the first phase of the next output cycle.
    always_comb begin
        req_lat   = cmd.cmd_wr ? wrlat_act : rdlat_act;
        req_start = 8'(cmd.cmd_phase) + 8'(req_lat);
        req_end   = req_start + 8'(burst_act);
        for (int i = 0; i < pTL_LEN; i++) begin
            req_mask[i] = (8'(i) >= req_start) && (8'(i) < req_end);
        end
        req_collide = cmd.cmd_wr ? |(req_mask & wr_tl_en) : |(req_mask & rd_tl_en);
        req_bad     = req_collide
                    | ({1'b0, cmd.cmd_phase} >= n_act)
                    | ({1'b0, req_lat} > MAX_LAT_V)
                    | (burst_act == 5'd0)
                    | ({1'b0, burst_act} > MAX_BURST_V);
        req_fire    = cmd.cmd_valid & ready;
        req_ins     = req_fire & ~req_bad;
    end

    // ---------------- merge and shift ----------------
    always_comb begin
        for (int i = 0; i < pTL_LEN; i++) begin
            wr_mrg_en[i]   = wr_tl_en[i] | (req_ins & cmd.cmd_wr & req_mask[i]);
            rd_mrg_en[i]   = rd_tl_en[i] | (req_ins & ~cmd.cmd_wr & req_mask[i]);
            wr_mrg_rank[i] = (req_ins & cmd.cmd_wr & req_mask[i])  ? cmd.cmd_rank : wr_tl_rank[i];
            rd_mrg_rank[i] = (req_ins & ~cmd.cmd_wr & req_mask[i]) ? cmd.cmd_rank : rd_tl_rank[i];
            wr_nxt_rank[i] = '0;
            rd_nxt_rank[i] = '0;
        end
        wr_nxt_en = wr_mrg_en >> n_act;
        rd_nxt_en = rd_mrg_en >> n_act;
        case (n_act)
            3'd1: begin
                for (int i = 0; i < pTL_LEN - 1; i++) begin
                    wr_nxt_rank[i] = wr_mrg_rank[i + 1];
                    rd_nxt_rank[i] = rd_mrg_rank[i + 1];
                end
            end
            3'd2: begin
                for (int i = 0; i < pTL_LEN - 2; i++) begin
                    wr_nxt_rank[i] = wr_mrg_rank[i + 2];
                    rd_nxt_rank[i] = rd_mrg_rank[i + 2];
                end
            end
            default: begin
                for (int i = 0; i < pTL_LEN - 4; i++) begin
                    wr_nxt_rank[i] = wr_mrg_rank[i + 4];
                    rd_nxt_rank[i] = rd_mrg_rank[i + 4];
                end
            end
        endcase
    end

    // Phases at or beyond N are forced to 0. Slots there belong to the
    // next cycle and are still in the shifted timeline.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_bit_d[k] = (3'(k) < n_act) & wr_mrg_en[k];
            rd_bit_d[k] = (3'(k) < n_act) & rd_mrg_en[k];
            wr_cs_d[k]  = wr_bit_d[k] ? onehot(wr_mrg_rank[k]) : '0;
            rd_cs_d[k]  = rd_bit_d[k] ? onehot(rd_mrg_rank[k]) : '0;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_tl_en <= '0;
            rd_tl_en <= '0;
            for (int i = 0; i < pTL_LEN; i++) begin
                wr_tl_rank[i] <= '0;
                rd_tl_rank[i] <= '0;
            end
            wr_bit_q <= '0;
            rd_bit_q <= '0;
            for (int k = 0; k < 4; k++) begin
                wr_cs_q[k] <= '0;
                rd_cs_q[k] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            wr_tl_en <= wr_nxt_en;
            rd_tl_en <= rd_nxt_en;
            for (int i = 0; i < pTL_LEN; i++) begin
                wr_tl_rank[i] <= wr_nxt_rank[i];
                rd_tl_rank[i] <= rd_nxt_rank[i];
            end
            wr_bit_q <= wr_bit_d;
            rd_bit_q <= rd_bit_d;
            for (int k = 0; k < 4; k++) begin
                wr_cs_q[k] <= wr_cs_d[k];
                rd_cs_q[k] <= rd_cs_d[k];
            end
            err_q <= req_fire & req_bad;
        end
    end

    // ---------------- DFI outputs ----------------
    assign dfi_wrdata_en_P0 = {pDFI_WRDATA_EN_WIDTH{wr_bit_q[0]}};
    assign dfi_wrdata_en_P1 = {pDFI_WRDATA_EN_WIDTH{wr_bit_q[1]}};
    assign dfi_wrdata_en_P2 = {pDFI_WRDATA_EN_WIDTH{wr_bit_q[2]}};
    assign dfi_wrdata_en_P3 = {pDFI_WRDATA_EN_WIDTH{wr_bit_q[3]}};
    assign dfi_wrdata_cs_P0 = wr_cs_q[0];
    assign dfi_wrdata_cs_P1 = wr_cs_q[1];
    assign dfi_wrdata_cs_P2 = wr_cs_q[2];
    assign dfi_wrdata_cs_P3 = wr_cs_q[3];
    assign dfi_rddata_en_P0 = {pDFI_RDDATA_EN_WIDTH{rd_bit_q[0]}};
    assign dfi_rddata_en_P1 = {pDFI_RDDATA_EN_WIDTH{rd_bit_q[1]}};
    assign dfi_rddata_en_P2 = {pDFI_RDDATA_EN_WIDTH{rd_bit_q[2]}};
    assign dfi_rddata_en_P3 = {pDFI_RDDATA_EN_WIDTH{rd_bit_q[3]}};
    assign dfi_rddata_cs_P0 = rd_cs_q[0];
    assign dfi_rddata_cs_P1 = rd_cs_q[1];
    assign dfi_rddata_cs_P2 = rd_cs_q[2];
    assign dfi_rddata_cs_P3 = rd_cs_q[3];

endmodule

// File: tb/tb_dfi_data_sched.sv
// Self-checking bench for dfi_data_sched. A reference model keeps the
// expected enables per absolute (cycle, phase), plus the FSM and config.
// Each step drives one cycle of stimulus and pushes the expected output word
// for the next cycle into exp_q. The word is popped and compared half a
// cycle after the next rising edge.
`timescale 1ns/1ps
module tb_dfi_data_sched;
    localparam int CSW = 2;
    localparam int WEW = 3;
    localparam int REW = 3;
    localparam int XW  = 43;
    localparam int MC  = 1200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       cfg_update;
    logic [1:0] cfg_freq_ratio;
    logic [5:0] cfg_tphy_wrlat, cfg_trddata_en;
    logic [4:0] cfg_burst;
    logic [WEW-1:0] wr_en0, wr_en1, wr_en2, wr_en3;
    logic [CSW-1:0] wr_cs0, wr_cs1, wr_cs2, wr_cs3;
    logic [REW-1:0] rd_en0, rd_en1, rd_en2, rd_en3;
    logic [CSW-1:0] rd_cs0, rd_cs1, rd_cs2, rd_cs3;
    logic       sched_idle;
    logic [1:0] fsm_state;

    dfi_data_sched_if #(.pDFI_CS_WIDTH(CSW)) cmd_if ();

    dfi_data_sched dut (
        .clk(clk), .rst(rst), .cmd(cmd_if.slave),
        .cfg_update(cfg_update), .cfg_freq_ratio(cfg_freq_ratio),
        .cfg_tphy_wrlat(cfg_tphy_wrlat), .cfg_trddata_en(cfg_trddata_en),
        .cfg_burst(cfg_burst),
        .dfi_wrdata_en_P0(wr_en0), .dfi_wrdata_en_P1(wr_en1),
        .dfi_wrdata_en_P2(wr_en2), .dfi_wrdata_en_P3(wr_en3),
        .dfi_wrdata_cs_P0(wr_cs0), .dfi_wrdata_cs_P1(wr_cs1),
        .dfi_wrdata_cs_P2(wr_cs2), .dfi_wrdata_cs_P3(wr_cs3),
        .dfi_rddata_en_P0(rd_en0), .dfi_rddata_en_P1(rd_en1),
        .dfi_rddata_en_P2(rd_en2), .dfi_rddata_en_P3(rd_en3),
        .dfi_rddata_cs_P0(rd_cs0), .dfi_rddata_cs_P1(rd_cs1),
        .dfi_rddata_cs_P2(rd_cs2), .dfi_rddata_cs_P3(rd_cs3),
        .sched_idle(sched_idle), .fsm_state(fsm_state)
    );

    // {err, ready, idle, rd_cs[39:32], rd_en[31:20], wr_cs[19:12], wr_en[11:0]}
    logic [XW-1:0] obs;
    assign obs = {cmd_if.cmd_err, cmd_if.cmd_ready, sched_idle,
                  rd_cs3, rd_cs2, rd_cs1, rd_cs0, rd_en3, rd_en2, rd_en1, rd_en0,
                  wr_cs3, wr_cs2, wr_cs1, wr_cs0, wr_en3, wr_en2, wr_en1, wr_en0};

    // ---------------- reference model ----------------
    bit         m_wr_en [MC][4];
    bit         m_rd_en [MC][4];
    logic [1:0] m_wr_rk [MC][4];
    logic [1:0] m_rd_rk [MC][4];
    int m_state;                 // 0 RUN, 1 DRAIN, 2 LOAD
    int m_n, m_wrlat, m_rdlat, m_burst;
    int c_ratio, c_wrlat, c_rdlat, c_burst;
    int cyc;
    logic [XW-1:0] exp_q[$];
    int errors, checks;

    function automatic int ratio_n(input int r);
        return (r == 0) ? 1 : ((r == 1) ? 2 : 4);
    endfunction

    function automatic bit m_busy_after(input int t);
        for (int oc = t + 1; oc < t + 80 && oc < MC; oc++)
            for (int k = 0; k < 4; k++)
                if (m_wr_en[oc][k] || m_rd_en[oc][k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XW-1:0] exp_word(input int oc, input bit err, input bit rdy, input bit idle);
        logic [XW-1:0] w;
        w = '0;
        w[42] = err;
        w[41] = rdy;
        w[40] = idle;
        for (int k = 0; k < 4; k++) begin
            w[k*3 +: 3]      = m_wr_en[oc][k] ? 3'b111 : 3'b000;
            w[12 + k*2 +: 2] = m_wr_en[oc][k] ? (2'b01 << m_wr_rk[oc][k]) : 2'b00;
            w[20 + k*3 +: 3] = m_rd_en[oc][k] ? 3'b111 : 3'b000;
            w[32 + k*2 +: 2] = m_rd_en[oc][k] ? (2'b01 << m_rd_rk[oc][k]) : 2'b00;
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < MC; c++)
            for (int k = 0; k < 4; k++) begin
                m_wr_en[c][k] = 1'b0;
                m_rd_en[c][k] = 1'b0;
                m_wr_rk[c][k] = 2'd0;
                m_rd_rk[c][k] = 2'd0;
            end
        m_state = 0;
        m_n = 4; m_wrlat = 0; m_rdlat = 0; m_burst = 1;
        c_ratio = 2; c_wrlat = 0; c_rdlat = 0; c_burst = 1;
        cyc = 0;
        exp_q.delete();
    endtask

    task automatic check_cycle();
        logic [XW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (obs[39:0] === e[39:0]) else begin
            errors++;
            $error("FAIL dfi cyc=%0d got=%h exp=%h", cyc, obs[39:0], e[39:0]);
        end
        checks++;
        assert (obs[42] === e[42]) else begin
            errors++;
            $error("FAIL cmd_err cyc=%0d got=%b exp=%b", cyc, obs[42], e[42]);
        end
        checks++;
        assert (obs[41:40] === e[41:40]) else begin
            errors++;
            $error("FAIL ready_idle cyc=%0d got=%b exp=%b", cyc, obs[41:40], e[41:40]);
        end
    endtask

    // Drive one cycle of stimulus. Called at a falling edge; returns at the
    // next falling edge after checking that cycle's outputs.
    task automatic step(input bit v, input bit wr, input logic [1:0] rk, input logic [1:0] ph,
                        input bit upd, input int ratio, input int wl, input int rl, input int bl);
        bit rdy, err, rej;
        int lat, s, oc, k;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_wr    = wr;
        cmd_if.cmd_rank  = rk;
        cmd_if.cmd_phase = ph;
        cfg_update       = upd;
        cfg_freq_ratio   = 2'(ratio);
        cfg_tphy_wrlat   = 6'(wl);
        cfg_trddata_en   = 6'(rl);
        cfg_burst        = 5'(bl);
        rdy = (m_state == 0);
        err = 1'b0;
        if (v && rdy) begin
            lat = wr ? m_wrlat : m_rdlat;
            rej = (int'(ph) >= m_n) || (lat > 40) || (m_burst == 0) || (m_burst > 16);
            if (!rej)
                for (int j = 0; j < m_burst; j++) begin
                    s = int'(ph) + lat + j;
                    oc = cyc + 1 + s / m_n;
                    k = s % m_n;
                    if (wr ? m_wr_en[oc][k] : m_rd_en[oc][k]) rej = 1'b1;
                end
            if (!rej)
                for (int j = 0; j < m_burst; j++) begin
                    s = int'(ph) + lat + j;
                    oc = cyc + 1 + s / m_n;
                    k = s % m_n;
                    if (wr) begin m_wr_en[oc][k] = 1'b1; m_wr_rk[oc][k] = rk; end
                    else    begin m_rd_en[oc][k] = 1'b1; m_rd_rk[oc][k] = rk; end
                end
            err = rej;
        end
        if (upd) begin
            c_ratio = ratio; c_wrlat = wl; c_rdlat = rl; c_burst = bl;
        end
        case (m_state)
            0: if (upd) m_state = 1;
            1: if (!m_busy_after(cyc)) m_state = 2;
            default: begin
                m_n = ratio_n(c_ratio);
                m_wrlat = c_wrlat; m_rdlat = c_rdlat; m_burst = c_burst;
                m_state = 0;
            end
        endcase
        exp_q.push_back(exp_word(cyc + 1, err, m_state == 0, (m_state == 0) && !m_busy_after(cyc + 1)));
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic configure(input int r, input int wl, input int rl, input int bl);
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, r, wl, rl, bl);
        for (int i = 0; i < 20 && m_state != 0; i++) idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_wr = 1'b0;
        cmd_if.cmd_rank = 2'd0;  cmd_if.cmd_phase = 2'd0;
        cfg_update = 1'b0; cfg_freq_ratio = 2'd0;
        cfg_tphy_wrlat = 6'd0; cfg_trddata_en = 6'd0; cfg_burst = 5'd0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        assert (obs === {1'b0, 1'b1, 1'b1, 40'd0}) else begin
            errors++;
            $error("FAIL reset_state got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 40'd0});
        end
        rst = 1'b0;

        // Basic write, 1:4, wrlat 5, burst 4, rank 1 at phase 2.
        configure(2, 5, 5, 4);
        idle(2);
        step(1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        checks++;
        assert ({wr_en3, wr_cs3, wr_en0} === {3'b111, 2'b10, 3'b000}) else begin
            errors++;
            $error("FAIL basic_first got=%b_%b_%b exp=111_10_000", wr_en3, wr_cs3, wr_en0);
        end
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        checks++;
        assert ({wr_en0, wr_en1, wr_en2, wr_en3} === {3'b111, 3'b111, 3'b111, 3'b000}) else begin
            errors++;
            $error("FAIL basic_second got=%b %b %b %b exp=111 111 111 000", wr_en0, wr_en1, wr_en2, wr_en3);
        end
        idle(2);

        // Collision, 1:2, rdlat 3, burst 4.
        configure(1, 5, 3, 4);
        step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 0, 0, 0, 0);
        checks++;
        assert (cmd_if.cmd_err === 1'b1) else begin
            errors++;
            $error("FAIL collision_err got=%b exp=1", cmd_if.cmd_err);
        end
        idle(5);

        // Gapless back-to-back, 1:1, wrlat 2, burst 2, rank change.
        configure(0, 2, 0, 2);
        step(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        idle(1);
        step(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 0, 0, 0, 0);
        idle(6);

        // Illegal phase for 1:2.
        configure(1, 2, 2, 2);
        step(1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 0, 0, 0, 0);
        idle(4);

        // Latency and burst limits.
        configure(2, 41, 40, 2);
        step(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 0, 0, 0, 0);
        idle(13);
        configure(2, 0, 0, 0);
        step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        configure(2, 0, 0, 17);
        step(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        configure(2, 0, 0, 16);
        step(1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        idle(6);

        // Random traffic, 1:4.
        configure(2, 7, 9, 3);
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'b0, 0, 0, 0, 0);
        idle(6);

        // Config drain: request in the update cycle, newer update during DRAIN.
        configure(2, 8, 8, 8);
        step(1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 0, 1, 1, 2);
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 0, 3, 2, 2);
        for (int i = 0; i < 20 && m_state != 0; i++) idle(1);
        step(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);
        idle(6);

        // Reset in the middle of a 16-phase read.
        configure(2, 2, 4, 16);
        step(1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 0, 0, 0, 0);
        idle(2);
        #2 rst = 1'b1;
        #1;
        checks++;
        assert (obs === {1'b0, 1'b1, 1'b1, 40'd0}) else begin
            errors++;
            $error("FAIL async_reset got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 40'd0});
        end
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        checks++;
        assert (obs === {1'b0, 1'b1, 1'b1, 40'd0}) else begin
            errors++;
            $error("FAIL post_reset got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 40'd0});
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dfi_data_sched.md
# dfi_data_sched

DFI data-phase scheduler that sits between the command generator and the DFI data interface of the PHY channel. It accepts one read or write burst request per cycle and drives the per-phase enable and chip-select signals, for phases P0..P3, at the programmed DFI latency: `dfi_wrdata_en`/`dfi_wrdata_cs` at tphy_wrlat and `dfi_rddata_en`/`dfi_rddata_cs` at trddata_en. It handles 1:1, 1:2 and 1:4 frequency ratios. Configuration changes go through a drain handshake, so they never corrupt bursts already in flight.

## Interface
- pDFI_CS_WIDTH, 2, rank field width; cs outputs are one-hot of this width per phase
- pDFI_WRDATA_EN_WIDTH, 3, per-phase write-enable width (enable bit replicated)
- pDFI_RDDATA_EN_WIDTH, 3, per-phase read-enable width (replicated)
- pMAX_LAT, 40, maximum legal latency in DFI phases
- pMAX_BURST, 16, maximum burst length in DFI phases
- pTL_LEN, 64, timeline depth in phases; must be ≥ pMAX_LAT+pMAX_BURST+4
- clk  in  1  DFI clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  burst request
- cmd_ready  out  1  request accepted when cmd_valid&cmd_ready
- cmd_wr  in  1  1=write, 0=read
- cmd_rank  in  pDFI_CS_WIDTH  target rank (binary)
- cmd_phase  in  2  DFI phase the command occupies
- cmd_err  out  1  one-cycle pulse: last accepted request was rejected
- cfg_update  in  1  pulse: load new cfg_* values
- cfg_freq_ratio  in  2  0=1:1, 1=1:2, 2/3=1:4
- cfg_tphy_wrlat  in  6  write latency, phases
- cfg_trddata_en  in  6  read latency, phases
- cfg_burst  in  5  burst length, phases (1..pMAX_BURST)
- dfi_wrdata_en_P0..P3  out  pDFI_WRDATA_EN_WIDTH each
- dfi_wrdata_cs_P0..P3  out  pDFI_CS_WIDTH each
- dfi_rddata_en_P0..P3  out  pDFI_RDDATA_EN_WIDTH each
- dfi_rddata_cs_P0..P3  out  pDFI_CS_WIDTH each
- sched_idle  out  1  both timelines empty and FSM in RUN

## Operation
- Active config registers (N, wrlat, rdlat, burst) are loaded only in state LOAD. Reset values: N=4, wrlat=0, rdlat=0, burst=1.
- Two independent timelines, write and read. Each slot holds one enable bit plus a rank, pTL_LEN slots each. Slot 0 is the first phase of the next output cycle.
- Accepted request: lat = wrlat or rdlat according to cmd_wr. Slots cmd_phase+lat .. cmd_phase+lat+burst-1 are set with rank cmd_rank.
- Rejection: the request is dropped and cmd_err pulses on the next cycle if any of these holds:
  - any target slot is already set in the same direction's timeline;
  - cmd_phase ≥ N;
  - lat > pMAX_LAT;
  - burst = 0 or burst > pMAX_BURST.
- A read and a write are independent; overlap between the two directions is not checked.
- Each cycle, slots 0..N-1 are registered onto P0..P(N-1) and the timeline shifts down by N.
  - en = {W{slot bit}}.
  - cs = one-hot(rank) when the bit is set, else 0.
  - Phases ≥ N are driven 0.
- FSM:
  - RUN: cmd_ready=1. cfg_update → DRAIN.
  - DRAIN: cmd_ready=0. Stays until both timelines are empty, then → LOAD.
  - LOAD: cmd_ready=0. Latches cfg_* (captured at the cfg_update pulse), → RUN.
- cfg_update while in DRAIN or LOAD: the newer values overwrite the captured copy, with no extra drain.
- A request presented in the same cycle as cfg_update is accepted under the old config.

## Timing
- Reset (async assert, sync release): all en/cs outputs 0, cmd_err=0, timelines cleared, FSM=RUN, cmd_ready=1, sched_idle=1.
- Latency: a request accepted in cycle c with phase p and latency L produces its first enable at absolute phase (c+1)·N + p + L.
  - Equivalently, output cycle c+1+⌊(p+L)/N⌋, phase (p+L) mod N.
  - L=0 means the enable appears in the next cycle, in the same phase.
- A burst crossing a cycle boundary continues contiguously in P0 of the following cycle.
- Back-to-back requests in consecutive cycles are legal whenever their slots do not collide. A burst ending at slot s followed by a burst starting at s+1 is gapless.
- cmd_err is registered: it asserts in cycle c+1 for a rejection in cycle c.
- DRAIN exits on the cycle after the last enable leaves the timeline. LOAD lasts exactly one cycle.
- Reset mid-burst truncates the burst immediately (asynchronously).

## Test plan
- **Basic write, 1:4:** wrlat=5, burst=4, write on rank 1 at phase 2 in cycle 10.
  - Cycle 12: wrdata_en P3=3'b111, cs P3=2'b10.
  - Cycle 13: P0..P2 enabled.
  - All other phases 0.
- **Collision:** 1:2, rdlat=3, burst=4. Read at cycle 0 phase 0, then read at cycle 1 phase 0.
  - The second read is rejected; cmd_err pulses at cycle 2.
  - Only the 4 phases of the first read appear.
- **Gapless back-to-back:** 1:1, wrlat=2, burst=2, writes in cycles 0 and 2.
  - wrdata_en is continuously high for cycles 3..6.
  - cs switches at cycle 5 when the second write uses a different rank.
- **Illegal phase:** 1:2, request with cmd_phase=3 → rejected, cmd_err pulses, P2/P3 stay 0 throughout.
- **Config drain:** bursts pending, then cfg_update changes the ratio to 1:1.
  - cmd_ready goes low until the last enable is emitted, then stays low for 1 LOAD cycle.
  - cmd_ready returns high and the new latency applies to the next request.
- **Reset mid-operation:** assert rst halfway through a 16-phase read.
  - Outputs go 0 asynchronously.
  - After release, sched_idle=1 and no residual enables appear.
